// File: rtl/alu_op_sequencer.sv
// Command sequencer in front of the registered ALU units: holds A/B/ALU_FUN while
// the units compute, captures the addressed unit's result and flag, and hands them off.
module alu_op_sequencer #(
    parameter int unsigned OP_WIDTH = 16,
    parameter int unsigned ALU_LAT  = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [OP_WIDTH-1:0]     cmd_a,
    input  logic [OP_WIDTH-1:0]     cmd_b,
    input  logic [3:0]              cmd_fun,
    output logic [OP_WIDTH-1:0]     alu_a,
    output logic [OP_WIDTH-1:0]     alu_b,
    output logic [3:0]              alu_fun,
    input  logic [2*OP_WIDTH-1:0]   arith_out,
    input  logic                    arith_flag,
    input  logic [OP_WIDTH-1:0]     logic_out,
    input  logic                    logic_flag,
    input  logic [OP_WIDTH-1:0]     cmp_out,
    input  logic                    cmp_flag,
    input  logic [OP_WIDTH-1:0]     shift_out,
    input  logic                    shift_flag,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [2*OP_WIDTH-1:0]   res_data,
    output logic                    res_flag,
    output logic [1:0]              res_class,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CAPT,
        DONE
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(ALU_LAT);

    state_t                  state;
    state_t                  state_nxt;
    logic [2:0]              lat_cnt;
    logic [2:0]              lat_cnt_nxt;
    logic                    accept;
    logic                    load_res;
    logic [2*OP_WIDTH-1:0]   sel_data;
    logic                    sel_flag;

    // DONE hands the slot straight to the next command in the cycle the result is taken
    assign cmd_ready = RST && ((state == IDLE) || ((state == DONE) && res_ready));
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE);

    always_comb begin : next_state_logic
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        load_res    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt   = EXEC;
                    lat_cnt_nxt = LAT_LOAD;
                end
            end
            EXEC: begin
                lat_cnt_nxt = lat_cnt - 3'd1;
                if (lat_cnt <= 3'd1) begin
                    state_nxt = CAPT;
                end
            end
            CAPT: begin
                load_res  = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    if (accept) begin
                        state_nxt   = EXEC;
                        lat_cnt_nxt = LAT_LOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin : result_select
        sel_data = '0;
        sel_flag = 1'b0;
        case (alu_fun[3:2])
            2'b00: begin
                sel_data = arith_out;
                sel_flag = arith_flag;
            end
            2'b01: begin
                sel_data[OP_WIDTH-1:0] = logic_out;
                sel_flag               = logic_flag;
            end
            2'b10: begin
                sel_data[OP_WIDTH-1:0] = cmp_out;
                sel_flag               = cmp_flag;
            end
            2'b11: begin
                sel_data[OP_WIDTH-1:0] = shift_out;
                sel_flag               = shift_flag;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin : ctrl_regs
        if (!RST) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            res_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            lat_cnt   <= lat_cnt_nxt;
            res_valid <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin : operand_regs
        if (!RST) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_fun <= '0;
        end else if (accept) begin
            alu_a   <= cmd_a;
            alu_b   <= cmd_b;
            alu_fun <= cmd_fun;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin : result_regs
        if (!RST) begin
            res_data  <= '0;
            res_flag  <= 1'b0;
            res_class <= '0;
        end else if (load_res) begin
            res_data  <= sel_data;
            res_flag  <= sel_flag;
            res_class <= alu_fun[3:2];
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: one instance with ALU_LAT=1, one with ALU_LAT=3,
// each fed by an ALU stub whose outputs lag the bench-driven values by ALU_LAT cycles.
module tb_alu_op_sequencer;

    typedef struct packed {
        logic [31:0] arith;
        logic        af;
        logic [15:0] lg;
        logic        lf;
        logic [15:0] cmp;
        logic        cf;
        logic [15:0] sh;
        logic        sf;
    } stub_t;

    localparam stub_t STALE = '{arith: 32'h0BAD_0BAD, af: 1'b0, lg: 16'h0BAD, lf: 1'b0,
                                cmp: 16'h0BAD, cf: 1'b0, sh: 16'h0BAD, sf: 1'b0};

    int vectors     = 0;
    int miscompares = 0;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // LAT=1 instance
    logic        rst_n, cmd_valid, cmd_ready, res_valid, res_ready, res_flag, busy;
    logic [15:0] cmd_a, cmd_b, alu_a, alu_b;
    logic [3:0]  cmd_fun, alu_fun;
    logic [31:0] res_data;
    logic [1:0]  res_class;
    stub_t       stub_in, stub_q;

    // LAT=3 instance
    logic        rst3_n, cmd_valid3, cmd_ready3, res_valid3, res_ready3, res_flag3, busy3;
    logic [15:0] cmd_a3, cmd_b3, alu_a3, alu_b3;
    logic [3:0]  cmd_fun3, alu_fun3;
    logic [31:0] res_data3;
    logic [1:0]  res_class3;
    stub_t       stub3_in, s3_d0, s3_d1, stub3_q;

    always_ff @(posedge CLK) stub_q <= stub_in;

    always_ff @(posedge CLK) begin
        s3_d0   <= stub3_in;
        s3_d1   <= s3_d0;
        stub3_q <= s3_d1;
    end

    alu_op_sequencer #(.OP_WIDTH(16), .ALU_LAT(1)) dut (
        .CLK(CLK), .RST(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fun(cmd_fun),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
        .arith_out(stub_q.arith), .arith_flag(stub_q.af),
        .logic_out(stub_q.lg), .logic_flag(stub_q.lf),
        .cmp_out(stub_q.cmp), .cmp_flag(stub_q.cf),
        .shift_out(stub_q.sh), .shift_flag(stub_q.sf),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_flag(res_flag), .res_class(res_class),
        .busy(busy)
    );

    alu_op_sequencer #(.OP_WIDTH(16), .ALU_LAT(3)) dut3 (
        .CLK(CLK), .RST(rst3_n),
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_a(cmd_a3), .cmd_b(cmd_b3), .cmd_fun(cmd_fun3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_fun(alu_fun3),
        .arith_out(stub3_q.arith), .arith_flag(stub3_q.af),
        .logic_out(stub3_q.lg), .logic_flag(stub3_q.lf),
        .cmp_out(stub3_q.cmp), .cmp_flag(stub3_q.cf),
        .shift_out(stub3_q.sh), .shift_flag(stub3_q.sf),
        .res_valid(res_valid3), .res_ready(res_ready3),
        .res_data(res_data3), .res_flag(res_flag3), .res_class(res_class3),
        .busy(busy3)
    );

    task automatic test_reset();
        rst_n  = 1'b0;
        rst3_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'($urandom);  cmd_a = 16'($urandom); cmd_b = 16'($urandom);
            cmd_fun   = 4'($urandom);  res_ready = 1'($urandom); stub_in = stub_t'({$urandom, $urandom, $urandom});
            cmd_valid3 = 1'($urandom); cmd_a3 = 16'($urandom); cmd_b3 = 16'($urandom);
            cmd_fun3   = 4'($urandom); res_ready3 = 1'($urandom); stub3_in = stub_t'({$urandom, $urandom, $urandom});
            @(posedge CLK); #1;
            vectors++;
            if (res_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_valid_busy: got res_valid=%b busy=%b want 0 0", res_valid, busy);
            end
            vectors++;
            if (alu_fun !== 4'h0 || alu_a !== 16'h0 || res_data !== 32'h0 || res_class !== 2'b00) begin
                miscompares++;
                $display("FAIL reset_regs: got alu_fun=%h alu_a=%h res_data=%h res_class=%0d want all 0",
                         alu_fun, alu_a, res_data, res_class);
            end
            vectors++;
            if (res_valid3 !== 1'b0 || busy3 !== 1'b0 || alu_fun3 !== 4'h0) begin
                miscompares++;
                $display("FAIL reset_lat3: got res_valid=%b busy=%b alu_fun=%h want 0 0 0",
                         res_valid3, busy3, alu_fun3);
            end
        end
        cmd_valid  = 1'b0; res_ready  = 1'b0; stub_in  = STALE;
        cmd_valid3 = 1'b0; res_ready3 = 1'b0; stub3_in = STALE;
        rst_n  = 1'b1;
        rst3_n = 1'b1;
        #1;
        vectors++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got cmd_ready=%b busy=%b want 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_arith();
        @(posedge CLK); #1;
        stub_in = STALE;
        cmd_a = 16'h00FF; cmd_b = 16'h0003; cmd_fun = 4'b0000; cmd_valid = 1'b1;
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL arith_cmd_ready: got %b want 1", cmd_ready);
        end
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        stub_in.arith = 32'h0000_0102; stub_in.af = 1'b1;
        vectors++;
        if (alu_a !== 16'h00FF || alu_b !== 16'h0003 || alu_fun !== 4'b0000 || busy !== 1'b1 || res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL arith_accept: got a=%h b=%h fun=%h busy=%b vld=%b want 00ff 0003 0 1 0",
                     alu_a, alu_b, alu_fun, busy, res_valid);
        end
        @(posedge CLK); #1;
        vectors++;
        if (res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL arith_edge1: got res_valid=%b want 0", res_valid);
        end
        @(posedge CLK); #1;
        vectors++;
        if (res_valid !== 1'b1 || res_data !== 32'h0000_0102 || res_flag !== 1'b1 || res_class !== 2'd0) begin
            miscompares++;
            $display("FAIL arith_result: got vld=%b data=%h flag=%b class=%0d want 1 00000102 1 0",
                     res_valid, res_data, res_flag, res_class);
        end
        res_ready = 1'b1;
        @(posedge CLK); #1;
        res_ready = 1'b0;
        vectors++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL arith_release: got vld=%b busy=%b want 0 0", res_valid, busy);
        end
    endtask

    // Leaves the result pending so test_backpressure starts in DONE.
    task automatic test_zero_ext();
        @(posedge CLK); #1;
        stub_in = STALE;
        cmd_a = 16'h0F0F; cmd_b = 16'h0004; cmd_fun = 4'b1101; cmd_valid = 1'b1;
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        stub_in.sh = 16'hFFFF; stub_in.sf = 1'b0;
        stub_in.arith = 32'hDEAD_BEEF; stub_in.af = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        vectors++;
        if (res_valid !== 1'b1 || res_data !== 32'h0000_FFFF || res_flag !== 1'b0 || res_class !== 2'd3) begin
            miscompares++;
            $display("FAIL zext_result: got vld=%b data=%h flag=%b class=%0d want 1 0000ffff 0 3",
                     res_valid, res_data, res_flag, res_class);
        end
    endtask

    task automatic test_backpressure();
        cmd_a = 16'h1234; cmd_b = 16'h5678; cmd_fun = 4'b0100; cmd_valid = 1'b1;
        stub_in = STALE;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            vectors++;
            if (res_valid !== 1'b1 || res_data !== 32'h0000_FFFF || res_class !== 2'd3 || cmd_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got vld=%b data=%h class=%0d cmd_ready=%b want 1 0000ffff 3 0",
                         i, res_valid, res_data, res_class, cmd_ready);
            end
            vectors++;
            if (alu_a !== 16'h0F0F || alu_b !== 16'h0004 || alu_fun !== 4'b1101) begin
                miscompares++;
                $display("FAIL bp_alu_hold[%0d]: got a=%h b=%h fun=%h want 0f0f 0004 d", i, alu_a, alu_b, alu_fun);
            end
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        #1;
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_cmd_ready_comb: got %b want 1", cmd_ready);
        end
        @(posedge CLK); #1;
        res_ready = 1'b0;
        vectors++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || alu_fun !== 4'b1101) begin
            miscompares++;
            $display("FAIL bp_release: got vld=%b busy=%b fun=%h want 0 0 d", res_valid, busy, alu_fun);
        end
    endtask

    task automatic test_back_to_back();
        int edges;
        int lat;
        bit got;
        logic [15:0] exp_lg;
        @(posedge CLK); #1;
        stub_in = STALE;
        cmd_a = 16'h0001; cmd_b = 16'h0010; cmd_fun = 4'b0000; cmd_valid = 1'b1;
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        stub_in.arith = 32'h0000_0011; stub_in.af = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        vectors++;
        if (res_valid !== 1'b1 || res_data !== 32'h0000_0011) begin
            miscompares++;
            $display("FAIL b2b_first: got vld=%b data=%h want 1 00000011", res_valid, res_data);
        end
        edges = 0;
        for (int i = 0; i < 4; i++) begin
            exp_lg = 16'h0100 + 16'(i);
            res_ready = 1'b1; cmd_valid = 1'b1;
            cmd_a = 16'h0010 + 16'(i); cmd_b = 16'h0001; cmd_fun = 4'b0100;
            stub_in = STALE;
            #1;
            vectors++;
            if (cmd_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_cmd_ready[%0d]: got %b want 1", i, cmd_ready);
            end
            @(posedge CLK); #1;
            edges++;
            cmd_valid = 1'b0; res_ready = 1'b0;
            stub_in.lg = exp_lg; stub_in.lf = ((i % 2) == 1);
            vectors++;
            if (res_valid !== 1'b0 || alu_a !== (16'h0010 + 16'(i)) || alu_fun !== 4'b0100) begin
                miscompares++;
                $display("FAIL b2b_accept[%0d]: got vld=%b a=%h fun=%h want 0 %h 4",
                         i, res_valid, alu_a, alu_fun, 16'h0010 + 16'(i));
            end
            lat = 0;
            got = 1'b0;
            for (int k = 0; k < 8; k++) begin
                @(posedge CLK); #1;
                edges++;
                lat++;
                if (res_valid === 1'b1) begin
                    got = 1'b1;
                    break;
                end
            end
            vectors++;
            if (!got || lat != 2) begin
                miscompares++;
                $display("FAIL b2b_latency[%0d]: got %0d edges (seen=%0d) want 2", i, lat, got);
            end
            vectors++;
            if (res_class !== 2'd1 || res_data !== {16'h0000, exp_lg} || res_flag !== ((i % 2) == 1)) begin
                miscompares++;
                $display("FAIL b2b_result[%0d]: got class=%0d data=%h flag=%b want 1 %h %0d",
                         i, res_class, res_data, res_flag, {16'h0000, exp_lg}, (i % 2));
            end
        end
        vectors++;
        if (edges != 12) begin
            miscompares++;
            $display("FAIL b2b_total_cycles: got %0d want 12", edges);
        end
        res_ready = 1'b1;
        @(posedge CLK); #1;
        res_ready = 1'b0;
        vectors++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle: got busy=%b vld=%b want 0 0", busy, res_valid);
        end
    endtask

    task automatic test_midop_reset();
        int lat;
        bit got;
        bit seen_valid;
        @(posedge CLK); #1;
        stub3_in = STALE;
        cmd_a3 = 16'h0001; cmd_b3 = 16'h0002; cmd_fun3 = 4'b1000; cmd_valid3 = 1'b1;
        @(posedge CLK); #1;
        cmd_valid3 = 1'b0;
        stub3_in.cmp = 16'h0077; stub3_in.cf = 1'b1;
        vectors++;
        if (busy3 !== 1'b1 || alu_fun3 !== 4'b1000) begin
            miscompares++;
            $display("FAIL mid_accept: got busy=%b fun=%h want 1 8", busy3, alu_fun3);
        end
        @(posedge CLK); #1;
        rst3_n = 1'b0;
        #1;
        vectors++;
        if (busy3 !== 1'b0 || res_valid3 !== 1'b0 || alu_fun3 !== 4'h0 || alu_a3 !== 16'h0 || res_data3 !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_abort: got busy=%b vld=%b fun=%h a=%h data=%h want 0 0 0 0 0",
                     busy3, res_valid3, alu_fun3, alu_a3, res_data3);
        end
        rst3_n = 1'b1;
        #1;
        vectors++;
        if (cmd_ready3 !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_cmd_ready: got %b want 1", cmd_ready3);
        end
        seen_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK); #1;
            if (res_valid3 !== 1'b0 || busy3 !== 1'b0) seen_valid = 1'b1;
        end
        vectors++;
        if (seen_valid) begin
            miscompares++;
            $display("FAIL mid_no_result: got stray res_valid/busy after abort, want none");
        end
        stub3_in = STALE;
        cmd_a3 = 16'h00AB; cmd_b3 = 16'h0000; cmd_fun3 = 4'b1100; cmd_valid3 = 1'b1;
        @(posedge CLK); #1;
        cmd_valid3 = 1'b0;
        stub3_in.sh = 16'h00AB; stub3_in.sf = 1'b1;
        lat = 0;
        got = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge CLK); #1;
            lat++;
            if (res_valid3 === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        vectors++;
        if (!got || lat != 4) begin
            miscompares++;
            $display("FAIL mid_latency: got %0d edges (seen=%0d) want 4", lat, got);
        end
        vectors++;
        if (res_data3 !== 32'h0000_00AB || res_class3 !== 2'd3 || res_flag3 !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_result: got data=%h class=%0d flag=%b want 000000ab 3 1",
                     res_data3, res_class3, res_flag3);
        end
        res_ready3 = 1'b1;
        @(posedge CLK); #1;
        res_ready3 = 1'b0;
        vectors++;
        if (res_valid3 !== 1'b0 || busy3 !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_release: got vld=%b busy=%b want 0 0", res_valid3, busy3);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_arith();
        test_zero_ext();
        test_backpressure();
        test_back_to_back();
        test_midop_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Upstream command stage for the 16-bit unsigned ALU top. It accepts operand/function commands over a valid/ready handshake and holds A, B and ALU_FUN stable while the registered ALU units compute. It selects the result and flag of the unit addressed by ALU_FUN[3:2], zero-extends the result to 2*OP_WIDTH, and presents it on a valid/ready result port. One command is in flight at a time; back-to-back issue is allowed when the result is consumed.

Parameters:
OP_WIDTH, 16, operand width; results are 2*OP_WIDTH wide.
ALU_LAT, 1, ALU register latency in cycles (1..7) between stable inputs and valid unit outputs.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge
cmd_a  in  OP_WIDTH  operand A
cmd_b  in  OP_WIDTH  operand B
cmd_fun  in  4  ALU function code
alu_a  out  OP_WIDTH  to ALU A (registered)
alu_b  out  OP_WIDTH  to ALU B (registered)
alu_fun  out  4  to ALU ALU_FUN (registered)
arith_out  in  2*OP_WIDTH  ALU Arith_OUT
arith_flag  in  1  ALU Arith_Flag
logic_out  in  OP_WIDTH  ALU Logic_OUT
logic_flag  in  1  ALU Logic_Flag
cmp_out  in  OP_WIDTH  ALU CMP_OUT
cmp_flag  in  1  ALU CMP_Flag
shift_out  in  OP_WIDTH  ALU SHIFT_OUT
shift_flag  in  1  ALU SHIFT_Flag
res_valid  out  1  result present
res_ready  in  1  consumer accepts result
res_data  out  2*OP_WIDTH  selected result, zero-extended for non-arith classes
res_flag  out  1  selected unit flag
res_class  out  2  ALU_FUN[3:2] of the completed command
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (RST low, async): state=IDLE. alu_a, alu_b, alu_fun, res_data, res_flag, res_class and the latency counter are 0. res_valid=0 and busy=0; cmd_ready=1 once RST is released.
- State IDLE: cmd_ready=1. On accept, register cmd_a/b/fun into alu_a/b/fun, load the counter with ALU_LAT, and go to EXEC.
- State EXEC: alu_* are held. The counter decrements each cycle. When the counter reaches 1 on an edge, go to CAPT.
- State CAPT (1 cycle): sample the unit outputs selected by alu_fun[3:2]:
  - 00 selects arith_out and arith_flag.
  - 01 selects logic_out and logic_flag.
  - 10 selects cmp_out and cmp_flag.
  - 11 selects shift_out and shift_flag.
  - 16-bit results are zero-extended in the upper half.
  - Load res_class, set res_valid=1 and go to DONE.
- Latency: with ALU_LAT=1, res_valid rises 2 edges after the accept edge.
- State DONE: res_data, res_flag and res_class are stable while res_valid=1.
  - On res_ready=1, clear res_valid.
  - In the same cycle, cmd_ready=1 (combinational on res_ready). A simultaneous cmd_valid is accepted and the state goes directly to EXEC with new alu_* values. Otherwise go to IDLE.
  - When res_ready=0, cmd_ready=0 and the state holds.
- alu_* hold their last values in IDLE/DONE and never change except on an accept edge.
- cmd_valid with cmd_ready=0 is ignored; there is no queuing.
- Reset asserted mid-operation aborts the command immediately. There is no result, and all outputs return to their reset values.

Test Plan:
The bench uses an ALU stub that registers its outputs ALU_LAT cycles after alu_* change.
- Reset: hold RST=0 with random inputs -> res_valid=0, busy=0, alu_fun=0, res_data=0; after release, cmd_ready=1.
- Arith: cmd_a=16'h00FF, cmd_b=16'h0003, cmd_fun=4'b0000; stub arith_out=32'h0000_0102, flag=1 -> res_valid 2 edges after accept, res_data=32'h0000_0102, res_flag=1, res_class=0.
- Zero-extend: cmd_fun=4'b1101; stub shift_out=16'hFFFF, flag=0, while arith_out=32'hDEAD_BEEF -> res_data=32'h0000_FFFF, res_class=3.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid -> res_data stable, cmd_ready=0, a presented command is not accepted, alu_* unchanged.
- Back-to-back: res_ready=1 and cmd_valid=1 with fun=4'b0100 in DONE -> same-edge accept, res_valid drops for 2 cycles, next result has res_class=1; 4 consecutive commands complete in 12 cycles.
- Mid-op reset with ALU_LAT=3: pulse RST low during EXEC -> immediate IDLE, no res_valid afterward; a following command completes normally with 4-edge latency.
